// File: rtl/vga_vidmem_responder.sv
// Purpose: responder that arbitrates framebuffer reads and CPU pixel writes onto one async SRAM.
// Latency: in-range access is ACCESS_CYCLES+1 cycles from grant to completion (RDONE/WDONE);
//          out-of-range requests complete after 1 cycle.
// Backpressure: bus_wait/cpu_wait hold each requester until its access finishes. After a read,
//          a write that waited through it wins the next grant.
//
// Ports:
//   clock, reset_n                       - system clock, async active-low reset
//   bus_read, address, bus_wait, data    - framebuffer read port (data valid in RDONE)
//   cpu_write, cpu_address, cpu_data,
//   cpu_wait                             - CPU write port (cpu_wait low for one WDONE cycle)
//   sram_addr, sram_wdata, sram_rdata    - SRAM word address, write data, read data
//   sram_ce_n, sram_oe_n, sram_we_n      - registered active-low SRAM strobes
module vga_vidmem_responder #(
    parameter logic [31:0] VIDMEM        = 32'h00c00000,
    parameter int          DEPTH_BITS    = 19,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  bus_read,
    input  logic [31:0]           address,
    output logic                  bus_wait,
    output logic [23:0]           data,
    input  logic                  cpu_write,
    input  logic [31:0]           cpu_address,
    input  logic [23:0]           cpu_data,
    output logic                  cpu_wait,
    output logic [DEPTH_BITS-1:0] sram_addr,
    output logic [23:0]           sram_wdata,
    input  logic [23:0]           sram_rdata,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RDONE,
        WRITE,
        WDONE
    } state_t;

    state_t                  state_q, state_d;
    logic [23:0]             data_q, data_d;
    logic [DEPTH_BITS-1:0]   addr_q, addr_d;
    logic [23:0]             wdata_q, wdata_d;
    logic                    ce_n_q, ce_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    we_n_q, we_n_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    cpu_prio_q, cpu_prio_d;

    // Window offsets; unsigned wrap makes addresses below VIDMEM fall out of range too.
    logic [31:0] rd_off, wr_off;
    logic        rd_in_range, wr_in_range;

    assign rd_off      = address - VIDMEM;
    assign wr_off      = cpu_address - VIDMEM;
    assign rd_in_range = (rd_off >> DEPTH_BITS) == 32'd0;
    assign wr_in_range = (wr_off >> DEPTH_BITS) == 32'd0;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        cnt_d      = cnt_q;
        cpu_prio_d = cpu_prio_q;

        case (state_q)
            IDLE: begin
                // A read wins unless a write was left waiting behind the previous read.
                if (bus_read && (!cpu_prio_q || !cpu_write)) begin
                    if (rd_in_range) begin
                        addr_d  = rd_off[DEPTH_BITS-1:0];
                        ce_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                        cnt_d   = CNT_INIT;
                        state_d = READ;
                    end else begin
                        data_d  = '0;
                        state_d = RDONE;
                    end
                end else if (cpu_write) begin
                    if (wr_in_range) begin
                        addr_d  = wr_off[DEPTH_BITS-1:0];
                        wdata_d = cpu_data;
                        ce_n_d  = 1'b0;
                        we_n_d  = 1'b0;
                        cnt_d   = CNT_INIT;
                        state_d = WRITE;
                    end else begin
                        state_d = WDONE;
                    end
                end
            end
            READ: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    data_d  = sram_rdata;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    state_d = RDONE;
                end
            end
            RDONE: begin
                if (!bus_read) begin
                    cpu_prio_d = cpu_write;
                    state_d    = IDLE;
                end
            end
            WRITE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    ce_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    state_d = WDONE;
                end
            end
            WDONE: begin
                cpu_prio_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            cnt_q      <= '0;
            cpu_prio_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            cnt_q      <= cnt_d;
            cpu_prio_q <= cpu_prio_d;
        end
    end

    assign bus_wait   = bus_read & (state_q != RDONE);
    assign cpu_wait   = cpu_write & (state_q != WDONE);
    assign data       = data_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_vga_vidmem_responder.sv
module tb_vga_vidmem_responder;

    logic        clock;
    logic        reset_n;
    logic        bus_read;
    logic [31:0] address;
    logic        bus_wait;
    logic [23:0] data;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic [23:0] cpu_data;
    logic        cpu_wait;
    logic [18:0] sram_addr;
    logic [23:0] sram_wdata;
    logic [23:0] sram_rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    int checks   = 0;
    int failures = 0;

    localparam byte OR_R = 8'd82;
    localparam byte OR_W = 8'd87;

    typedef struct {
        logic [23:0] dat;
        int          waits;
        int          oes;
    } rd_exp_t;

    typedef struct {
        logic [18:0] addr;
        logic [23:0] wdata;
        int          wes;
        bit          in_range;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    byte     ord_q[$];

    vga_vidmem_responder #(
        .VIDMEM       (32'h00c00000),
        .DEPTH_BITS   (19),
        .ACCESS_CYCLES(2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus_read   (bus_read),
        .address    (address),
        .bus_wait   (bus_wait),
        .data       (data),
        .cpu_write  (cpu_write),
        .cpu_address(cpu_address),
        .cpu_data   (cpu_data),
        .cpu_wait   (cpu_wait),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Small SRAM model: 32 words are enough for the addresses exercised.
    logic [23:0] mem [0:31];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 24'h010101 * i;
        mem[16] = 24'h123456;
    end
    always_comb sram_rdata = sram_oe_n ? 24'hdeadbe : mem[sram_addr[4:0]];
    always @(posedge clock) if (!sram_ce_n && !sram_we_n) mem[sram_addr[4:0]] = sram_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          rd_wait_cnt, oe_cnt, we_cnt;
    bit          rd_seen;
    logic [18:0] cap_addr;
    logic [23:0] cap_wdata;
    rd_exp_t     mon_rd;
    wr_exp_t     mon_wr;

    always @(negedge clock) begin
        if (!reset_n) begin
            rd_wait_cnt = 0;
            oe_cnt      = 0;
            we_cnt      = 0;
            rd_seen     = 0;
        end else begin
            if (!sram_oe_n || !sram_we_n) begin
                chk("strobe_overlap", {31'd0, (!sram_oe_n && !sram_we_n)}, 32'd0);
                chk("ce_with_strobe", {31'd0, sram_ce_n}, 32'd0);
            end
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) begin
                we_cnt++;
                cap_addr  = sram_addr;
                cap_wdata = sram_wdata;
            end
            if (bus_read && bus_wait) rd_wait_cnt++;
            if (bus_read && !bus_wait && !rd_seen) begin
                rd_seen = 1;
                if (rd_q.size() == 0) fail_now("rd_unexpected");
                else begin
                    mon_rd = rd_q.pop_front();
                    chk("rd_data", {8'd0, data}, {8'd0, mon_rd.dat});
                    chk("rd_wait_cycles", rd_wait_cnt, mon_rd.waits);
                    chk("rd_oe_cycles", oe_cnt, mon_rd.oes);
                end
                if (ord_q.size() == 0) fail_now("order_unexpected_read");
                else chk("order", {24'd0, OR_R}, {24'd0, ord_q.pop_front()});
                rd_wait_cnt = 0;
                oe_cnt      = 0;
            end
            if (!bus_read) rd_seen = 0;
            if (cpu_write && !cpu_wait) begin
                if (wr_q.size() == 0) fail_now("wr_unexpected");
                else begin
                    mon_wr = wr_q.pop_front();
                    chk("wr_we_cycles", we_cnt, mon_wr.wes);
                    if (mon_wr.in_range) begin
                        chk("wr_addr", {13'd0, cap_addr}, {13'd0, mon_wr.addr});
                        chk("wr_data", {8'd0, cap_wdata}, {8'd0, mon_wr.wdata});
                    end
                end
                if (ord_q.size() == 0) fail_now("order_unexpected_write");
                else chk("order", {24'd0, OR_W}, {24'd0, ord_q.pop_front()});
                we_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic fb_read(input logic [31:0] a, input logic [23:0] exp_d,
                           input int waits, input int oes);
        int n;
        @(posedge clock);
        #1;
        rd_q.push_back('{exp_d, waits, oes});
        bus_read = 1'b1;
        address  = a;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus_wait && n < 200);
        if (bus_wait) fail_now("rd_timeout");
        @(posedge clock);
        #1;
        bus_read = 1'b0;
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [23:0] d,
                          input int wes, input bit in_range);
        int n;
        @(posedge clock);
        #1;
        wr_q.push_back('{a[18:0], d, wes, in_range});
        cpu_write   = 1'b1;
        cpu_address = a;
        cpu_data    = d;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (cpu_wait && n < 200);
        if (cpu_wait) fail_now("wr_timeout");
        @(posedge clock);
        #1;
        cpu_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        bus_read    = 1'b0;
        address     = '0;
        cpu_write   = 1'b0;
        cpu_address = '0;
        cpu_data    = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_data", {8'd0, data}, 32'd0);
        chk("rst_sram_addr", {13'd0, sram_addr}, 32'd0);
        chk("rst_sram_wdata", {8'd0, sram_wdata}, 32'd0);
        chk("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        chk("rst_bus_wait", {31'd0, bus_wait}, 32'd0);
        chk("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);

        // In-range read, then out-of-range reads on both sides of the window.
        ord_q.push_back(OR_R);
        fb_read(32'h00c00010, 24'h123456, 3, 2);
        ord_q.push_back(OR_R);
        fb_read(32'h00bfffff, 24'h000000, 1, 0);
        ord_q.push_back(OR_R);
        fb_read(32'h00c00010, 24'h123456, 3, 2);
        ord_q.push_back(OR_R);
        fb_read(32'h00c80000, 24'h000000, 1, 0);

        // CPU write, read back; out-of-range write is dropped.
        ord_q.push_back(OR_W);
        cpu_wr(32'h00c00005, 24'hff00aa, 2, 1'b1);
        ord_q.push_back(OR_W);
        cpu_wr(32'h00000000, 24'h777777, 0, 1'b0);
        ord_q.push_back(OR_R);
        fb_read(32'h00c00005, 24'hff00aa, 3, 2);

        // Burst with a write arriving during the first read: write goes next,
        // second read waits 5 IDLE/WRITE/WDONE cycles plus its own 2 READ cycles.
        ord_q.push_back(OR_R);
        ord_q.push_back(OR_W);
        ord_q.push_back(OR_R);
        ord_q.push_back(OR_R);
        fork
            begin
                fb_read(32'h00c00010, 24'h123456, 3, 2);
                fb_read(32'h00c00008, 24'habcdef, 7, 2);
                fb_read(32'h00c00005, 24'hff00aa, 3, 2);
            end
            begin
                repeat (2) @(posedge clock);
                cpu_wr(32'h00c00008, 24'habcdef, 2, 1'b1);
            end
        join

        // Simultaneous first requests: read first.
        ord_q.push_back(OR_R);
        ord_q.push_back(OR_W);
        fork
            fb_read(32'h00c00010, 24'h123456, 3, 2);
            cpu_wr(32'h00c00003, 24'h0f0f0f, 2, 1'b1);
        join

        // Reset pulsed during READ with one count remaining.
        @(posedge clock);
        #1;
        bus_read = 1'b1;
        address  = 32'h00c00010;
        @(posedge clock);
        #1;
        chk("pre_rst_oe_low", {31'd0, sram_oe_n}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        chk("midrst_data", {8'd0, data}, 32'd0);
        chk("midrst_bus_wait_hi", {31'd0, bus_wait}, 32'd1);
        bus_read = 1'b0;
        #1;
        chk("midrst_bus_wait_lo", {31'd0, bus_wait}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Recovery after reset.
        ord_q.push_back(OR_R);
        fb_read(32'h00c00003, 24'h0f0f0f, 3, 2);

        repeat (3) @(posedge clock);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("ord_q_drained", ord_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_vidmem_responder.md
Name: vga_vidmem_responder

Overview:
- Memory-side responder for the video framebuffer's read bus (bus_read/bus_wait/address/data).
- Also accepts pixel writes from the CPU side and arbitrates both onto one external asynchronous SRAM with a fixed multi-cycle access time.
- Sits between the framebuffer scanline fetcher, the CPU write path and the SRAM pins, all in one clock domain.

Parameters:
- VIDMEM, 32'h00c00000, byte-free word base address of the video window on both request ports.
- DEPTH_BITS, 19, SRAM word-address width; the window spans 2^DEPTH_BITS words.
- ACCESS_CYCLES, 2, SRAM cycles per access (>=1); strobes are held this many cycles.

Ports:
- clock  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- bus_read  in  1  framebuffer read request; held high until bus_wait is sampled low.
- address  in  32  framebuffer read word address; stable while bus_read is high.
- bus_wait  out  1  combinational: bus_read & ~(state==RDONE).
- data  out  24  read data {r,g,b}; valid while state==RDONE.
- cpu_write  in  1  CPU write request; held until cpu_wait is sampled low.
- cpu_address  in  32  CPU write word address.
- cpu_data  in  24  CPU write data.
- cpu_wait  out  1  combinational: cpu_write & ~(state==WDONE).
- sram_addr  out  DEPTH_BITS  registered SRAM word address.
- sram_wdata  out  24  registered SRAM write data.
- sram_rdata  in  24  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  registered active-low strobes.

Behaviour:
- Reset (async): state=IDLE; data=0; sram_addr=0; sram_wdata=0; all strobes=1; cnt=0; cpu_prio=0. bus_wait and cpu_wait follow their equations, so they are 0 with no request.
- Offset computation: off = req_address - VIDMEM, 32-bit. The address is in range iff off < 2^DEPTH_BITS. sram_addr = off[DEPTH_BITS-1:0].
- State IDLE, grant rules:
  - bus_read=1 and (cpu_prio=0 or cpu_write=0) -> read.
  - Else if cpu_write=1 -> write.
  - Read grant, in range: latch sram_addr; ce_n=0, oe_n=0; cnt=ACCESS_CYCLES-1; go to READ.
  - Read grant, out of range: data<=0; go to RDONE; no strobes.
  - Write grant, in range: latch sram_addr and sram_wdata; ce_n=0, we_n=0; cnt=ACCESS_CYCLES-1; go to WRITE.
  - Write grant, out of range: go to WDONE; write dropped; no strobes.
- State READ: if cnt!=0 then cnt--. If cnt==0 then data<=sram_rdata, strobes->1, go to RDONE.
- State RDONE: data held stable. When bus_read==0 go to IDLE.
  - On leaving, cpu_prio <= cpu_write, so a write waiting through a read wins the next grant.
- State WRITE: if cnt!=0 then cnt--. If cnt==0 then strobes->1, go to WDONE.
- State WDONE: exactly one cycle (cpu_wait=0); cpu_prio<=0; go to IDLE.
  - If cpu_write is still high in IDLE, that is a new transaction.
- In-range read latency: bus_read first seen high in IDLE at cycle t. bus_wait is high for cycles t..t+ACCESS_CYCLES and low from t+ACCESS_CYCLES+1.
- Out-of-range read: bus_wait high for 1 cycle, then data=0.
- bus_read dropping during READ (requester reset): the SRAM access completes, then RDONE exits immediately.
- No back-to-back strobes: at least one IDLE cycle with all strobes high separates any two accesses.
- Simultaneous first requests with cpu_prio=0: the read wins.
- Reset mid-access: strobes go high asynchronously; no partial state survives.

Test Plan:
- ACCESS_CYCLES=2, bus_read=1, address=32'h00c00010, sram_rdata=24'h123456.
  - Required: sram_addr=0x10, oe_n low 2 cycles, bus_wait high 3 cycles, then data=24'h123456 and bus_wait=0 until bus_read drops.
- Read at address=32'h00bfffff and at 32'h00c00000+2^19.
  - Required: no strobe activity, bus_wait high 1 cycle, data=0.
- CPU write cpu_address=32'h00c00005, cpu_data=24'hff00aa, no video traffic.
  - Required: sram_addr=5, sram_wdata=24'hff00aa, we_n low 2 cycles, cpu_wait low in exactly 1 cycle, then IDLE.
- Framebuffer-style burst (bus_read high, drops 1 cycle after bus_wait low, re-raises next cycle) with cpu_write asserted mid-burst.
  - Required: the write is granted immediately after the current read; the next read waits; no strobe overlap.
- Both requests rise together from IDLE with cpu_prio=0.
  - Required: read served first, write second.
- reset_n pulsed low during READ with cnt=1.
  - Required: strobes=1 and state IDLE immediately; data=0; bus_wait follows bus_read.
